axis_threshold_calibrator: RTL
==============================

// Module: axis_threshold_calibrator
// PURPOSE
//  Auto-calibrates the fringe-counter thresholds (FC_lower/upper_threshold) of the position tracker.
//  On a start request it observes channel A of the I/Q sample stream over a 2^N window, tracks min/max,
//  derives center and hysteresis band, and applies new thresholds atomically. Sits beside the tracker,
//  tapping the same AXIS sample stream; its FC_* outputs drive the tracker's threshold inputs.
// PARAMETERS
//  S_AXIS_TDATA_WIDTH   32  packed sample width; signal_a = low half, signal_b = high half (unused here)
//  MAX_WINDOW_LOG       20  upper clamp for cfg_window_log; sample counter width = MAX_WINDOW_LOG+1
//  MIN_AMPLITUDE        64  minimum (max-min) accepted; smaller spans are rejected as no-signal
// PORTS
//  aclk                  in   1     clock
//  aresetn               in   1     reset, synchronous, active-low
//  cfg_start             in   1     one-cycle start pulse; ignored while busy
//  cfg_window_log        in   5     window = 2^cfg_window_log samples, latched at start
//  cfg_hyst_shift        in   4     hysteresis = amplitude >> cfg_hyst_shift, latched at start
//  S_AXIS_tvalid         in   1     sample valid
//  S_AXIS_tdata          in   W     packed samples {signal_b, signal_a}, signed W/2 each
//  S_AXIS_tready         out  1     tied 1 (pure observer, never stalls stream)
//  FC_lower_threshold    out  W/2   signed applied lower threshold
//  FC_upper_threshold    out  W/2   signed applied upper threshold
//  busy                  out  1     high from start acceptance until done/error
//  done                  out  1     one-cycle pulse: new thresholds applied
//  error                 out  1     one-cycle pulse: amplitude < MIN_AMPLITUDE, thresholds unchanged
//  stat_min, stat_max    out  W/2   signed min/max of last completed window (updated on done and error)
// BEHAVIOUR
//  Reset: state IDLE; FC_* = 0, stat_* = 0, busy/done/error = 0; min/max/count cleared.
//  States: IDLE -> ACQUIRE -> COMPUTE -> APPLY -> IDLE; COMPUTE -> IDLE on reject (error).
//  IDLE: cfg_start=1 -> latch window_log (clamped to MAX_WINDOW_LOG), hyst_shift (0 treated as 1);
//   min <= +max signed, max <= -max signed, count <= 0; busy <= 1; go ACQUIRE.
//  ACQUIRE: each cycle with tvalid: min/max updated with $signed(signal_a) (compare against
//   register values including the current sample, so a single-sample window gives min=max=sample);
//   count++. On accept of sample number 2^N (count == 2^N-1) -> COMPUTE. tvalid=0 cycles do not count.
//  COMPUTE (1 cycle, registered): W/2+1-bit signed arithmetic, no overflow:
//   amplitude = max - min; center = (max + min) >>> 1 (floor); hyst = amplitude >> hyst_shift;
//   lower = center - hyst; upper = center + hyst; both saturated to signed W/2 range.
//   amplitude < MIN_AMPLITUDE -> error pulse, stat_* updated, busy<=0, IDLE.
//  APPLY: FC_lower/upper updated in the same cycle (never torn), stat_* updated, done pulse, busy<=0.
//  Latency: done asserted 2 cycles after the aclk edge accepting the final window sample.
//  FC_* hold previous values throughout ACQUIRE/COMPUTE; only APPLY changes them.
//  cfg_start while busy: ignored, no restart. cfg_start in the APPLY/error cycle: ignored;
//   accepted in the next IDLE cycle.
//  Reset mid-operation: abort immediately to reset values; FC_* return to 0.
//  Invariant: FC_lower_threshold <= FC_upper_threshold whenever applied.
// STRUCTURE
//  Shared package: state encodings (IDLE/ACQUIRE/COMPUTE/APPLY, 2-bit), signed min/max init constants,
//   saturation helper function for W/2+1 -> W/2 signed.
//  One sub-module: axis_minmax_accumulator (clear, valid, sample -> running signed min/max, count).
//  Remainder (FSM, compute, apply registers) is flat in this module.
// TESTING
//  window_log=2, hyst_shift=2, samples a=100,-100,50,-50 -> lower=-50, upper=50, done 2 cycles after 4th.
//  window_log=3 with tvalid gaps every other cycle -> exactly 8 valid samples consumed, gaps not counted.
//  amplitude 40 (<64) -> error pulse, FC_* retain prior values, stat_min/max = observed extremes.
//  extremes a=32767,-32768, hyst_shift=1 -> center=-1, lower=-32768, upper=32766, no wrap.
//  cfg_start pulsed during ACQUIRE -> ignored; single done; aresetn low mid-ACQUIRE -> all outputs 0.
//  hyst_shift=0, window_log=31 -> treated as shift 1 and window 2^MAX_WINDOW_LOG samples.

Source files
------------

// File: rtl/axis_threshold_calibrator_pkg.sv
// Shared types and helpers for the threshold calibrator: FSM encoding,
// signed range limits and saturation from a wide signed value to W bits.
package axis_threshold_calibrator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_COMPUTE = 2'd2,
      ST_APPLY   = 2'd3
   } state_t;

   function automatic logic signed [63:0] signed_max(input int unsigned w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] signed_min(input int unsigned w);
      return -(64'sd1 <<< (w - 1));
   endfunction

   // Clamp to the w-bit signed range; the result is still carried in 64 bits.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int unsigned w);
      if (v > signed_max(w)) return signed_max(w);
      if (v < signed_min(w)) return signed_min(w);
      return v;
   endfunction

endpackage

// File: rtl/axis_minmax_accumulator.sv
// Running signed min/max and sample count; clear seeds min/max so that the
// first accepted sample becomes both extremes.
module axis_minmax_accumulator
   import axis_threshold_calibrator_pkg::*;
#(
   parameter int unsigned SAMPLE_W = 16,
   parameter int unsigned CNT_W    = 21
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       clear,
   input  logic                       valid,
   input  logic signed [SAMPLE_W-1:0] sample,
   output logic signed [SAMPLE_W-1:0] run_min,
   output logic signed [SAMPLE_W-1:0] run_max,
   output logic        [CNT_W-1:0]    count
);

   localparam logic signed [SAMPLE_W-1:0] INIT_MIN = SAMPLE_W'(signed_max(SAMPLE_W));
   localparam logic signed [SAMPLE_W-1:0] INIT_MAX = SAMPLE_W'(signed_min(SAMPLE_W));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         run_min <= '0;
         run_max <= '0;
         count   <= '0;
      end else if (clear) begin
         run_min <= INIT_MIN;
         run_max <= INIT_MAX;
         count   <= '0;
      end else if (valid) begin
         if (sample < run_min) run_min <= sample;
         if (sample > run_max) run_max <= sample;
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/axis_threshold_calibrator.sv
// Observes channel A over a 2^N sample window, derives a centred hysteresis
// band from the observed extremes and applies both thresholds in one cycle.
module axis_threshold_calibrator
   import axis_threshold_calibrator_pkg::*;
#(
   parameter int unsigned S_AXIS_TDATA_WIDTH = 32,
   parameter int unsigned MAX_WINDOW_LOG     = 20,
   parameter int unsigned MIN_AMPLITUDE      = 64
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   input  logic                                 cfg_start,
   input  logic        [4:0]                    cfg_window_log,
   input  logic        [3:0]                    cfg_hyst_shift,
   input  logic                                 S_AXIS_tvalid,
   input  logic        [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
   output logic                                 S_AXIS_tready,
   output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] FC_lower_threshold,
   output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] FC_upper_threshold,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 error,
   output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] stat_min,
   output logic signed [S_AXIS_TDATA_WIDTH/2-1:0] stat_max
);

   localparam int unsigned HW    = S_AXIS_TDATA_WIDTH / 2;
   localparam int unsigned EW    = HW + 1;
   localparam int unsigned CNT_W = MAX_WINDOW_LOG + 1;
   localparam logic [4:0]  MAX_LOG = 5'(MAX_WINDOW_LOG);
   localparam logic signed [EW-1:0] MIN_AMP = $signed(EW'(MIN_AMPLITUDE));

   state_t               state;
   logic [4:0]           window_log;
   logic [3:0]           hyst_shift;
   logic signed [HW-1:0] lower_q, upper_q;
   logic signed [HW-1:0] signal_a, acc_min, acc_max;
   logic [CNT_W-1:0]     acc_count, last_index;
   logic                 start_accept, sample_accept, window_last;

   assign S_AXIS_tready = 1'b1;
   assign signal_a      = $signed(S_AXIS_tdata[HW-1:0]);
   assign start_accept  = (state == ST_IDLE) && cfg_start;
   assign sample_accept = (state == ST_ACQUIRE) && S_AXIS_tvalid;
   assign last_index    = (CNT_W'(1) << window_log) - CNT_W'(1);
   assign window_last   = sample_accept && (acc_count == last_index);

   axis_minmax_accumulator #(
      .SAMPLE_W (HW),
      .CNT_W    (CNT_W)
   ) u_acc (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clear   (start_accept),
      .valid   (sample_accept),
      .sample  (signal_a),
      .run_min (acc_min),
      .run_max (acc_max),
      .count   (acc_count)
   );

   // One extra bit keeps span, sum and band edges exact before saturation.
   logic signed [EW-1:0] max_ext, min_ext, amplitude, center, hyst, lower_ext, upper_ext;
   logic signed [HW-1:0] lower_sat, upper_sat;
   logic                 too_small;

   assign max_ext   = {acc_max[HW-1], acc_max};
   assign min_ext   = {acc_min[HW-1], acc_min};
   assign amplitude = max_ext - min_ext;
   assign center    = (max_ext + min_ext) >>> 1;
   assign hyst      = amplitude >>> hyst_shift;
   assign lower_ext = center - hyst;
   assign upper_ext = center + hyst;
   assign lower_sat = HW'(saturate(64'(lower_ext), HW));
   assign upper_sat = HW'(saturate(64'(upper_ext), HW));
   assign too_small = amplitude < MIN_AMP;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state              <= ST_IDLE;
         window_log         <= '0;
         hyst_shift         <= '0;
         lower_q            <= '0;
         upper_q            <= '0;
         FC_lower_threshold <= '0;
         FC_upper_threshold <= '0;
         stat_min           <= '0;
         stat_max           <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         error              <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_start) begin
                  window_log <= (cfg_window_log > MAX_LOG) ? MAX_LOG : cfg_window_log;
                  hyst_shift <= (cfg_hyst_shift == 4'd0) ? 4'd1 : cfg_hyst_shift;
                  busy       <= 1'b1;
                  state      <= ST_ACQUIRE;
               end
            end
            ST_ACQUIRE: begin
               if (window_last) state <= ST_COMPUTE;
            end
            ST_COMPUTE: begin
               lower_q <= lower_sat;
               upper_q <= upper_sat;
               if (too_small) begin
                  stat_min <= acc_min;
                  stat_max <= acc_max;
                  error    <= 1'b1;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  state <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               FC_lower_threshold <= lower_q;
               FC_upper_threshold <= upper_q;
               stat_min           <= acc_min;
               stat_max           <= acc_max;
               done               <= 1'b1;
               busy               <= 1'b0;
               state              <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
